// File: rtl/riscv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared constants and types for the fetch/decode pipeline boundary.
//   XLEN      datapath width
//   RESET_PC  PC value presented after reset and in every bubble
//   NOP_INST  bubble instruction (addi x0,x0,0)
//   SAT_MAX   terminal value of the 32-bit saturating performance counters
//   ifid_state_t  IF/ID sequencing state: BOOT (first edge after reset), RUN
// -----------------------------------------------------------------------------
package riscv_pipe_pkg;

    localparam int               XLEN     = 32;
    localparam logic [XLEN-1:0]  RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0]  NOP_INST = 32'h0000_0013;
    localparam logic [31:0]      SAT_MAX  = 32'hFFFF_FFFF;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } ifid_state_t;

endpackage : riscv_pipe_pkg

// File: rtl/ifid_sat_ctr.sv
// -----------------------------------------------------------------------------
// ifid_sat_ctr
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high clear
//   inc    in   count one event this edge
//   count  out  current count
// -----------------------------------------------------------------------------
module ifid_sat_ctr (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);
    import riscv_pipe_pkg::*;

    logic [31:0] r_count;

    // NOTE: state is written with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != SAT_MAX)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign count = r_count;

endmodule : ifid_sat_ctr

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Pairs the fetched instruction with its PC/PC+4 and
// hands them to decode. Handles load-use stall (hold), branch/jump flush
// (bubble), and the single bubble after reset. Works with combinational
// (SYNC_IMEM=0) or 1-cycle synchronous (SYNC_IMEM=1) instruction memory.
//
// Optional feature: define IFID_PERF_EN to add three saturating performance
// counters; otherwise perf_* are constant 0 and no counter flops exist.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   if_pc       in   current PC from the PC stage
//   if_pc4      in   PC+4 from the PC stage
//   if_inst     in   instruction memory read data
//   stall       in   load-use stall (also freezes the PC stage)
//   flush       in   taken branch/jump redirect
//   id_pc       out  PC of the instruction in ID
//   id_pc4      out  PC+4 of the instruction in ID
//   id_inst     out  instruction in ID
//   id_valid    out  1 = real instruction, 0 = bubble
//   perf_stall  out  RUN edges with stall and no flush
//   perf_flush  out  edges with flush
//   perf_bubble out  RUN edges that loaded a bubble
// -----------------------------------------------------------------------------
module if_id_reg #(
    parameter int                 XLEN      = riscv_pipe_pkg::XLEN,
    parameter logic [XLEN-1:0]    RESET_PC  = riscv_pipe_pkg::RESET_PC,
    parameter logic [XLEN-1:0]    NOP_INST  = riscv_pipe_pkg::NOP_INST,
    parameter bit                 SYNC_IMEM = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_pc4,
    input  logic [XLEN-1:0] if_inst,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic [XLEN-1:0] id_inst,
    output logic            id_valid,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_flush,
    output logic [31:0]     perf_bubble
);
    import riscv_pipe_pkg::*;

    localparam logic [XLEN-1:0] RESET_PC4 = RESET_PC + XLEN'(4);

    ifid_state_t     r_state;
    logic            r_kill;
    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_id_pc4;
    logic [XLEN-1:0] r_id_inst;
    logic            r_id_valid;

    logic [XLEN-1:0] w_fetch_pc;
    logic [XLEN-1:0] w_fetch_pc4;
    logic            w_run;
    logic            w_load_bubble;

    assign w_run         = (r_state == RUN);
    // A RUN edge loads a bubble on flush, or on a non-stalled edge that
    // squashes wrong-path data still in flight from the synchronous memory.
    assign w_load_bubble = w_run && (flush || (!stall && r_kill));

    // Align the PC with the instruction it produced. With synchronous memory
    // the data returned now belongs to last cycle's PC, so that PC is delayed
    // here. The BOOT edge always captures so the first RUN load is aligned.
    generate
        if (SYNC_IMEM) begin : g_sync_align
            logic [XLEN-1:0] r_pc_d;
            logic [XLEN-1:0] r_pc4_d;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pc_d  <= RESET_PC;
                    r_pc4_d <= RESET_PC4;
                end else if ((r_state == BOOT) || !stall) begin
                    r_pc_d  <= if_pc;
                    r_pc4_d <= if_pc4;
                end
            end

            assign w_fetch_pc  = r_pc_d;
            assign w_fetch_pc4 = r_pc4_d;
        end else begin : g_comb_align
            assign w_fetch_pc  = if_pc;
            assign w_fetch_pc4 = if_pc4;
        end
    endgenerate

    // Sequencer, kill flag and ID registers. Priority: rst > flush > stall > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BOOT;
            r_kill     <= 1'b0;
            r_id_pc    <= RESET_PC;
            r_id_pc4   <= RESET_PC4;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    // PC stage repeats RESET_PC once after reset; drop that copy.
                    r_state    <= RUN;
                    r_kill     <= 1'b0;
                    r_id_pc    <= RESET_PC;
                    r_id_pc4   <= RESET_PC4;
                    r_id_inst  <= NOP_INST;
                    r_id_valid <= 1'b0;
                end
                RUN: begin
                    if (w_load_bubble) begin
                        r_id_pc    <= RESET_PC;
                        r_id_pc4   <= RESET_PC4;
                        r_id_inst  <= NOP_INST;
                        r_id_valid <= 1'b0;
                        // Flush arms kill only when memory data lags by a cycle;
                        // a squashing load consumes it.
                        r_kill     <= flush && SYNC_IMEM;
                    end else if (!stall) begin
                        r_id_pc    <= w_fetch_pc;
                        r_id_pc4   <= w_fetch_pc4;
                        r_id_inst  <= if_inst;
                        r_id_valid <= 1'b1;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    assign id_pc    = r_id_pc;
    assign id_pc4   = r_id_pc4;
    assign id_inst  = r_id_inst;
    assign id_valid = r_id_valid;

`ifdef IFID_PERF_EN
    logic w_inc_stall;
    assign w_inc_stall = w_run && stall && !flush;

    ifid_sat_ctr u_ctr_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_stall),
        .count (perf_stall)
    );

    ifid_sat_ctr u_ctr_flush (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (perf_flush)
    );

    ifid_sat_ctr u_ctr_bubble (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_load_bubble),
        .count (perf_bubble)
    );
`else
    assign perf_stall  = '0;
    assign perf_flush  = '0;
    assign perf_bubble = '0;
`endif

endmodule : if_id_reg
